// File: rtl/adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_sequencer
// Description : Multi-channel ADC scan sequencer. A programmable sample tick
//               starts a scan over the channels enabled in chMask, in
//               ascending order. For each channel the sequencer drives the
//               analog mux select, pulses CONVST, waits for the conversion,
//               strobes CS/RD and captures D. Each captured word is offered
//               with its channel number on a valid/ready output register.
// Ports       : Clk, Rst      - clock / synchronous active-high reset
//               en, adcFr     - sample timer enable / rate (BASE_DIV>>adcFr)
//               chMask        - channel enable mask (bit i = channel i)
//               D             - ADC parallel data
//               BUSY          - ADC busy (only with ADC_BUSY_WAIT_EN)
//               CS, RD        - ADC chip select / read strobe, active-low
//               CONVST        - conversion start, active-low pulse
//               chSel         - analog mux select
//               sampleData/Ch/Valid, sampleReady - captured sample handshake
//               overrun       - pulse: capture dropped, output still full
//               missedTick    - pulse: tick arrived while a scan was running
// Config      : define ADC_BUSY_WAIT_EN to add the BUSY input; WAIT then ends
//               on the first cycle BUSY=0 is sampled, with a timeout of
//               WAIT_CYC*16 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_scan_sequencer #(
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 4,
  parameter int DIV_W      = 18,
  parameter int BASE_DIV   = 200000,
  parameter int SETTLE_CYC = 2,
  parameter int CONV_CYC   = 4,
  parameter int WAIT_CYC   = 4,
  parameter int RD_CYC     = 2,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              en,
  input  logic [2:0]        adcFr,
  input  logic [NUM_CH-1:0] chMask,
  input  logic [DATA_W-1:0] D,
`ifdef ADC_BUSY_WAIT_EN
  input  logic              BUSY,
`endif
  output logic              CS,
  output logic              RD,
  output logic              CONVST,
  output logic [CH_W-1:0]   chSel,
  output logic [DATA_W-1:0] sampleData,
  output logic [CH_W-1:0]   sampleCh,
  output logic              sampleValid,
  input  logic              sampleReady,
  output logic              overrun,
  output logic              missedTick
);

  // --------------------------------------------------------------------------
  // Phase counter sizing: must hold the longest per-state dwell.
  // --------------------------------------------------------------------------
`ifdef ADC_BUSY_WAIT_EN
  localparam int WAIT_MAX = WAIT_CYC * 16;
`else
  localparam int WAIT_MAX = WAIT_CYC;
`endif
  localparam int MAX_A  = (SETTLE_CYC > CONV_CYC) ? SETTLE_CYC : CONV_CYC;
  localparam int MAX_B  = (WAIT_MAX > RD_CYC) ? WAIT_MAX : RD_CYC;
  localparam int PH_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYC - 1);
  localparam logic [PH_W-1:0] CONV_LAST   = PH_W'(CONV_CYC - 1);
  localparam logic [PH_W-1:0] WAIT_LAST   = PH_W'(WAIT_MAX - 1);
  localparam logic [PH_W-1:0] RD_LAST     = PH_W'(RD_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CONV    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_READ    = 3'd4,
    ST_RECOVER = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t              state_q,  state_d;
  logic [PH_W-1:0]     phase_q,  phase_d;
  logic [DIV_W-1:0]    cnt_q,    cnt_d;
  logic [NUM_CH-1:0]   mask_q,   mask_d;
  logic [CH_W-1:0]     chsel_q,  chsel_d;
  logic                convst_q, convst_d;
  logic                rd_n_q,   rd_n_d;
  logic [DATA_W-1:0]   data_q,   data_d;
  logic [CH_W-1:0]     sch_q,    sch_d;
  logic                valid_q,  valid_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [DIV_W-1:0]    period_raw;
  logic [DIV_W-1:0]    period;
  logic                tick;
  logic                capture;
  logic                load;
  logic [CH_W-1:0]     first_ch;
  logic                first_found;
  logic [CH_W-1:0]     next_ch;
  logic                next_found;

  // Sample timer. The ">=" compare makes a period that shrinks below the
  // current count wrap immediately instead of running all the way round.
  always_comb begin
    period_raw = DIV_W'(BASE_DIV) >> adcFr;
    period     = (period_raw < DIV_W'(2)) ? DIV_W'(2) : period_raw;
    tick       = en && (cnt_q >= (period - DIV_W'(1)));
    if (!en) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  // Lowest enabled channel of the live mask (scan start) and the next higher
  // enabled channel of the latched mask (scan continuation).
  always_comb begin
    first_ch    = '0;
    first_found = 1'b0;
    next_ch     = '0;
    next_found  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (chMask[i] && !first_found) begin
        first_ch    = CH_W'(i);
        first_found = 1'b1;
      end
      if (mask_q[i] && !next_found && (CH_W'(i) > chsel_q)) begin
        next_ch    = CH_W'(i);
        next_found = 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    phase_d = phase_q + PH_W'(1);
    mask_d  = mask_q;
    chsel_d = chsel_q;
    capture = 1'b0;

    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (tick && first_found) begin
          state_d = ST_SETTLE;
          mask_d  = chMask;
          chsel_d = first_ch;
        end
      end

      ST_SETTLE: begin
        if (phase_q == SETTLE_LAST) begin
          state_d = ST_CONV;
          phase_d = '0;
        end
      end

      ST_CONV: begin
        if (phase_q == CONV_LAST) begin
          state_d = ST_WAIT;
          phase_d = '0;
        end
      end

      ST_WAIT: begin
`ifdef ADC_BUSY_WAIT_EN
        // Early exit as soon as the converter reports idle; the timeout
        // guards against a stuck BUSY line.
        if (!BUSY || (phase_q == WAIT_LAST)) begin
          state_d = ST_READ;
          phase_d = '0;
        end
`else
        if (phase_q == WAIT_LAST) begin
          state_d = ST_READ;
          phase_d = '0;
        end
`endif
      end

      ST_READ: begin
        if (phase_q == RD_LAST) begin
          capture = 1'b1;
          state_d = ST_RECOVER;
          phase_d = '0;
        end
      end

      ST_RECOVER: begin
        phase_d = '0;
        if (next_found) begin
          state_d = ST_SETTLE;
          chsel_d = next_ch;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
  end

  // Strobes are registered from the next state so the ADC pins are glitch
  // free and align exactly with the state dwell.
  always_comb begin
    convst_d = (state_d != ST_CONV);
    rd_n_d   = (state_d != ST_READ);
  end

  // Output register: a capture loads when the slot is empty or being drained
  // in the same cycle; otherwise the new word is dropped.
  always_comb begin
    load    = capture && (!valid_q || sampleReady);
    data_d  = data_q;
    sch_d   = sch_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = D;
      sch_d   = chsel_q;
      valid_d = 1'b1;
    end else if (valid_q && sampleReady) begin
      valid_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      chsel_q  <= '0;
      convst_q <= 1'b1;
      rd_n_q   <= 1'b1;
      data_q   <= '0;
      sch_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      chsel_q  <= chsel_d;
      convst_q <= convst_d;
      rd_n_q   <= rd_n_d;
      data_q   <= data_d;
      sch_q    <= sch_d;
      valid_q  <= valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // CS and RD are asserted together for the whole READ dwell.
  assign CS          = rd_n_q;
  assign RD          = rd_n_q;
  assign CONVST      = convst_q;
  assign chSel       = chsel_q;
  assign sampleData  = data_q;
  assign sampleCh    = sch_q;
  assign sampleValid = valid_q;
  // Event pulses are flagged in the very cycle the event is decided.
  assign overrun     = capture && valid_q && !sampleReady;
  assign missedTick  = tick && (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_scan_sequencer
// Description : Self-checking bench for adc_scan_sequencer. A behavioural
//               model derives every output from the scan timing rules
//               (tick arithmetic, list of channels, offset within a scan).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_scan_sequencer;

  localparam int S = 1;
  localparam int C = 2;
  localparam int W = 3;
  localparam int R = 2;
  localparam int T = S + C + W + R + 1;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       en;
  logic [2:0] adcFr;
  logic [3:0] chMask;
  logic [7:0] D;
  logic       sampleReady;
  logic       CS, RD, CONVST;
  logic [1:0] chSel, sampleCh;
  logic [7:0] sampleData;
  logic       sampleValid, overrun, missedTick;

  int total = 0;
  int bad   = 0;
  bit rnd_ready = 1'b0;

  // Reference model state
  int         m_cnt;
  bit         m_busy;
  int         m_ofs;
  int         m_chq[$];
  int         m_chsel;
  bit         m_valid;
  logic [7:0] m_data;
  int         m_ch;

  adc_scan_sequencer #(
    .DATA_W(8), .NUM_CH(4), .DIV_W(18), .BASE_DIV(64),
    .SETTLE_CYC(S), .CONV_CYC(C), .WAIT_CYC(W), .RD_CYC(R)
  ) dut (
    .Clk(Clk), .Rst(Rst), .en(en), .adcFr(adcFr), .chMask(chMask), .D(D),
    .CS(CS), .RD(RD), .CONVST(CONVST), .chSel(chSel),
    .sampleData(sampleData), .sampleCh(sampleCh), .sampleValid(sampleValid),
    .sampleReady(sampleReady), .overrun(overrun), .missedTick(missedTick)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_busy  = 1'b0;
    m_ofs   = 0;
    m_chq.delete();
    m_chsel = 0;
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_ch    = 0;
  endtask

  // Compare the DUT against the model for the current cycle, then advance
  // the model across the coming rising edge.
  task automatic model_cycle();
    int  p, k, o, e_chsel;
    bit  tick, e_conv, e_rd, cap, e_miss, e_ovr;
    p = 64 >> adcFr;
    if (p < 2) p = 2;
    tick    = en && (m_cnt >= p - 1);
    e_conv  = 1'b1;
    e_rd    = 1'b1;
    cap     = 1'b0;
    e_chsel = m_chsel;
    k = 0;
    o = 0;
    if (m_busy) begin
      k       = m_ofs / T;
      o       = m_ofs % T;
      e_chsel = m_chq[k];
      e_conv  = !(o >= S && o < S + C);
      e_rd    = !(o >= S + C + W && o < S + C + W + R);
      cap     = (o == S + C + W + R - 1);
    end
    e_miss = tick && m_busy;
    e_ovr  = cap && m_valid && !sampleReady;

    chk("CONVST",      32'(CONVST),      32'(e_conv));
    chk("CS",          32'(CS),          32'(e_rd));
    chk("RD",          32'(RD),          32'(e_rd));
    chk("chSel",       32'(chSel),       32'(e_chsel));
    chk("sampleValid", 32'(sampleValid), 32'(m_valid));
    chk("sampleData",  32'(sampleData),  32'(m_data));
    chk("sampleCh",    32'(sampleCh),    32'(m_ch));
    chk("overrun",     32'(overrun),     32'(e_ovr));
    chk("missedTick",  32'(missedTick),  32'(e_miss));

    if (!en)       m_cnt = 0;
    else if (tick) m_cnt = 0;
    else           m_cnt = m_cnt + 1;

    if (cap && (!m_valid || sampleReady)) begin
      m_data  = D;
      m_ch    = m_chq[k];
      m_valid = 1'b1;
    end else if (m_valid && sampleReady) begin
      m_valid = 1'b0;
    end

    if (m_busy) begin
      m_chsel = e_chsel;
      m_ofs   = m_ofs + 1;
      if (m_ofs == T * m_chq.size()) m_busy = 1'b0;
    end else if (tick && chMask != 4'b0000) begin
      m_chq.delete();
      for (int i = 0; i < 4; i++) if (chMask[i]) m_chq.push_back(i);
      m_busy  = 1'b1;
      m_ofs   = 0;
      m_chsel = m_chq[0];
    end
  endtask

  task automatic cyc(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge Clk);
      D = 8'($urandom);
      if (rnd_ready) sampleReady = 1'($urandom);
      #1;
      if (Rst) model_reset();
      else     model_cycle();
      @(posedge Clk);
      #1;
    end
  endtask

  function automatic bit model_in_conv();
    int o;
    o = m_ofs % T;
    return m_busy && (o >= S) && (o < S + C);
  endfunction

  initial begin
    bit found;
    Rst = 1'b1; en = 1'b0; adcFr = 3'd0; chMask = 4'b0000;
    D = 8'h00; sampleReady = 1'b1;
    model_reset();

    // Reset, then idle with the timer disabled
    cyc(2);
    Rst = 1'b0;
    cyc(200);

    // Single channel, full rate
    chMask = 4'b0001; en = 1'b1; adcFr = 3'd0;
    cyc(200);

    // Sparse mask: channels 1 and 3 only
    chMask = 4'b1010;
    cyc(150);

    // Back-pressure: second capture of a scan overruns
    sampleReady = 1'b0; chMask = 4'b0011;
    cyc(100);
    sampleReady = 1'b1;
    cyc(30);

    // Faster rates: P=16 fits a scan, P=2 forces missed ticks
    adcFr = 3'd2; chMask = 4'b0001;
    cyc(100);
    adcFr = 3'd5;
    cyc(60);
    chMask = 4'b1111;
    cyc(60);

    // Randomised operation, including mask changes mid-scan
    rnd_ready = 1'b1;
    for (int b = 0; b < 40; b++) begin
      chMask = 4'($urandom);
      adcFr  = 3'($urandom_range(1, 7));
      en     = ($urandom_range(0, 9) != 0);
      cyc($urandom_range(10, 60));
    end
    rnd_ready = 1'b0; sampleReady = 1'b1;

    // Reset in the middle of a conversion pulse
    en = 1'b1; adcFr = 3'd3; chMask = 4'b0100;
    found = 1'b0;
    for (int j = 0; j < 200 && !found; j++) begin
      cyc(1);
      found = model_in_conv();
    end
    total++;
    assert (found) else begin
      bad++;
      $error("FAIL conv_reach observed=0 expected=1");
    end
    Rst = 1'b1;
    cyc(1);
    Rst = 1'b0;
    cyc(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
